// File: rtl/div_uns_seq.sv
// Sequential radix-2 restoring divider for unsigned operands.
// Resolves one quotient bit per cycle; one operation in flight, valid/ready on both sides.
module div_uns_seq #(
    parameter int widthX = 8,
    parameter int widthY = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [widthX-1:0] X,
    input  logic [widthY-1:0] Y,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [widthX-1:0] Q,
    output logic [widthY-1:0] R,
    output logic              div_zero_o
);

    localparam int CW = (widthX > 1) ? $clog2(widthX) : 1;
    localparam logic [CW-1:0] LAST = CW'(widthX - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nx;
    logic [widthX-1:0] dvd, dvd_nx;
    logic [widthY-1:0] dvs;
    logic [widthY:0]   rem, rem_sh, rem_nx;
    logic [CW-1:0]     cnt;
    logic              zero;
    logic              ge;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nx;
    end

    // Handshake outputs decode from state only, so no input-to-output path exists.
    always_comb begin
        state_nx    = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nx = BUSY;
            end
            BUSY: if (cnt == LAST) state_nx = DONE;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One restoring step: partial remainder stays below Y, so widthY+1 bits never overflow.
    always_comb begin
        rem_sh    = {rem[widthY-1:0], dvd[widthX-1]};
        ge        = (rem_sh >= {1'b0, dvs});
        rem_nx    = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
        dvd_nx    = dvd << 1;
        dvd_nx[0] = ge;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            zero       <= 1'b0;
            Q          <= '0;
            R          <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    dvd  <= X;
                    dvs  <= Y;
                    rem  <= '0;
                    cnt  <= '0;
                    zero <= (Y == '0);
                end
                BUSY: begin
                    dvd <= dvd_nx;
                    rem <= rem_nx;
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                    if (cnt == LAST) begin
                        // With Y==0 nothing is subtracted, so the low remainder bits are X's low bits.
                        Q          <= zero ? '1 : dvd_nx;
                        R          <= rem_nx[widthY-1:0];
                        div_zero_o <= zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_uns_seq.md
Name: div_uns_seq

Overview:
Sequential radix-2 restoring divider for unsigned operands. It is the inverse companion to the unsigned partial-product multiplier in the arithmetic library. It accepts a dividend X and divisor Y over a valid/ready handshake and resolves one quotient bit per cycle. It returns quotient Q and remainder R over a second valid/ready handshake. One operation is in flight at a time.

Parameters:
widthX, 8, word width of dividend X and quotient Q (>=1)
widthY, 8, word width of divisor Y and remainder R (>=1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  operands X/Y valid
in_ready_o  output  1  divider can accept operands
X  input  widthX  dividend
Y  input  widthY  divisor
out_valid_o  output  1  Q/R/div_zero_o valid
out_ready_i  input  1  consumer accepts result
Q  output  widthX  quotient
R  output  widthY  remainder
div_zero_o  output  1  result came from a Y==0 operation

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; in_ready_o=1; out_valid_o=0; Q, R and div_zero_o all 0; iteration counter 0. Asserting reset mid-operation aborts it with no output.
- States: IDLE, BUSY, DONE. Outputs are registered or decoded from state only; there is no combinational path from in_valid_i or out_ready_i to any output.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o at edge t: latch X into the dividend shift register and Y into the divisor register; clear the partial remainder (widthY+1 bits) and counter; set the zero flag = (Y==0); go to BUSY.
- BUSY:
  - in_ready_o=0 and out_valid_o=0.
  - Each edge performs one iteration:
    - rem' = {rem[widthY-1:0], msb of dividend register}; shift the dividend register left.
    - If rem' >= {1'b0,Y}: rem = rem'-Y and the shifted-in quotient bit is 1. Otherwise rem = rem' and the quotient bit is 0.
    - Quotient bits shift into the vacated LSBs of the dividend register.
  - Exactly widthX iterations occur, at edges t+1..t+widthX, and the counter wraps exactly at widthX-1.
  - At edge t+widthX: load Q and R, set div_zero_o, go to DONE.
  - Latency: out_valid_o is high in the cycle after edge t+widthX. It is independent of operand values.
- Divide by zero (Y==0): same latency. Q = all ones, R = X[widthY-1:0] (zero-extended if widthX<widthY), div_zero_o=1. The iteration result is overridden. The partial remainder must not be allowed to overflow into a wrong R.
- DONE:
  - out_valid_o=1 and in_ready_o=0.
  - Q, R and div_zero_o hold stable until out_valid_o&&out_ready_i.
  - On that edge: go to IDLE; out_valid_o=0; Q, R and div_zero_o retain their values (do not clear).
  - A new operation can be accepted at the earliest on the next edge.
  - Back-to-back throughput is one result per widthX+2 cycles.
- in_valid_i is ignored while in BUSY or DONE. X and Y need only be stable in the handshake cycle.
- Invariant: X == Q*Y + R and R < Y for every Y != 0 and every width combination.

Test Plan:
- widthX=widthY=8, X=200, Y=7 -> exactly 8 cycles after accept, out_valid_o=1, Q=28, R=4, div_zero_o=0; in_ready_o=0 throughout.
- X=255, Y=1 -> Q=255, R=0. X=5, Y=9 -> Q=0, R=5. X=0, Y=255 -> Q=0, R=0. Latency is 8 in every case.
- X=77, Y=0 -> Q=255, R=77, div_zero_o=1, latency 8. A following 100/10 -> Q=10, R=0, div_zero_o=0.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE with in_valid_i=1 and changing X/Y -> Q/R stable, in_ready_o=0, no new accept. Release -> IDLE, then next operation accepted one edge later.
- Reset: drop rst_ni during the 3rd BUSY iteration -> out_valid_o=0 and in_ready_o=1 immediately; after release 9/2 -> Q=4, R=1.
- widthX=16, widthY=4: 65535/15 -> Q=4369, R=0 after 16 cycles; 1000/0 -> Q=0xFFFF, R=8, div_zero_o=1. Random 10k operations checked against X==Q*Y+R and R<Y.
